// File: rtl/display_pkg.sv
// Shared constants and types for the 7-segment display blocks.
package display_pkg;

    localparam int unsigned DIGITS    = 8;
    localparam int unsigned NIB_W     = 4;
    localparam int unsigned SEG_W     = 7;
    localparam logic [6:0]  SEG_OFF   = 7'h7F;
    localparam logic [7:0]  ANODE_OFF = 8'hFF;

    // Active-low segments, bit0=a .. bit6=g, indexed by hex value.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Per-frame snapshot of the register-file outputs.
    typedef struct packed {
        logic [31:0] digits;
        logic [7:0]  point;
        logic [3:0]  brightness;
        logic [7:0]  blank;
    } frame_t;

    localparam frame_t FRAME_RST = '{
        digits:     32'h0,
        point:      8'hFF,
        brightness: 4'h0,
        blank:      8'h00
    };

endpackage

// File: rtl/display_seg_decode.sv
// Combinational hex nibble to active-low 7-segment decoder.
module display_seg_decode
    import display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_c
);

    assign seg_c = HEX_SEG[hex];

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of eight 7-segment digits with frame latching,
// brightness PWM, guard time and leading-zero blanking.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned DIV   = 1024,
    parameter int unsigned GUARD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] digits,
    input  logic [7:0]  point,
    input  logic [3:0]  brightness,
    input  logic        blank_lz,
    output logic [7:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned CW   = $clog2(DIV);
    localparam int unsigned STEP = DIV / 16;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    frame_t        frame;

    logic          frame_start_c;
    logic          active_c;
    logic [CW:0]   on_end_c;
    logic [7:0]    blank_next_c;
    logic          run_c;
    logic [3:0]    cur_digit_c;
    logic [6:0]    cur_seg_c;

    assign frame_start_c = (cnt == '0) && (idx == 3'd0);

    // Slot prescaler and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // A digit is blanked only if it and every digit above it is zero with dp off.
    always_comb begin
        blank_next_c = '0;
        run_c        = blank_lz;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run_c           = run_c && (digits[k*NIB_W +: NIB_W] == 4'h0) && point[k];
            blank_next_c[k] = run_c;
        end
    end

    // Tear-free snapshot of the inputs at the start of each frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame <= FRAME_RST;
        end else if (frame_start_c) begin
            frame <= '{
                digits:     digits,
                point:      point,
                brightness: brightness,
                blank:      blank_next_c
            };
        end
    end

    assign on_end_c = (CW+1)'({1'b0, frame.brightness} + 5'd1) * (CW+1)'(STEP);

    assign active_c = en
                   && ({1'b0, cnt} >= (CW+1)'(GUARD))
                   && ({1'b0, cnt} < on_end_c)
                   && !frame.blank[idx];

    assign cur_digit_c = frame.digits[{idx, 2'b00} +: NIB_W];

    display_seg_decode u_decode (
        .hex   (cur_digit_c),
        .seg_c (cur_seg_c)
    );

    // Registered pin drive; guard cycles keep anodes off across idx changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            anode      <= ANODE_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_start_c;
            if (active_c) begin
                anode <= ~(8'h01 << idx);
                seg   <= cur_seg_c;
                dp    <= frame.point[idx];
            end else begin
                anode <= ANODE_OFF;
                seg   <= SEG_OFF;
                dp    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a cycle-level scoreboard.
module tb_display_scan_ctrl;

    localparam int DIV   = 32;
    localparam int GUARD = 2;
    localparam int FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] digits;
    logic [7:0]  point;
    logic [3:0]  brightness;
    logic        blank_lz;
    logic [7:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int n_cmp = 0;
    int n_bad = 0;

    logic [16:0] exp_q[$];

    int          m_cnt, m_idx;
    logic [31:0] m_dig;
    logic [7:0]  m_pt;
    logic [3:0]  m_br;
    logic [7:0]  m_bl;

    logic [7:0]  sel_mask;
    int          low_cnt;
    logic [6:0]  seen_seg [8];
    logic [7:0]  seen_dp;
    int          bad_seg;
    logic        found;

    display_scan_ctrl #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .digits     (digits),
        .point      (point),
        .brightness (brightness),
        .blank_lz   (blank_lz),
        .anode      (anode),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Blank every digit above the highest one that is nonzero or has its dp lit.
    function automatic logic [7:0] blank_of(input logic [31:0] d, input logic [7:0] p,
                                            input logic lz);
        logic [7:0] b;
        int top;
        top = 0;
        for (int k = 0; k < 8; k++)
            if (((d >> (4 * k)) & 32'hF) != 0 || !p[k]) top = k;
        b = 8'h00;
        if (lz)
            for (int k = 1; k < 8; k++)
                if (k > top) b[k] = 1'b1;
        return b;
    endfunction

    function automatic logic [16:0] model_out(input logic en_now);
        logic on;
        logic [3:0] nib;
        logic [7:0] an;
        on  = en_now && (m_cnt >= GUARD) && (m_cnt < (int'(m_br) + 1) * (DIV / 16))
              && !m_bl[m_idx];
        nib = 4'((m_dig >> (4 * m_idx)) & 32'hF);
        an  = 8'hFF;
        an[m_idx] = 1'b0;
        if (on) return {an, seg_of(nib), m_pt[m_idx], (m_cnt == 0 && m_idx == 0)};
        return {8'hFF, 7'h7F, 1'b1, (m_cnt == 0 && m_idx == 0)};
    endfunction

    // Reference model: push the expected registered outputs for every edge.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.push_back({8'hFF, 7'h7F, 1'b1, 1'b0});
            m_cnt <= 0;
            m_idx <= 0;
            m_dig <= 32'h0;
            m_pt  <= 8'hFF;
            m_br  <= 4'h0;
            m_bl  <= 8'h00;
        end else begin
            exp_q.push_back(model_out(en));
            if (m_cnt == 0 && m_idx == 0) begin
                m_dig <= digits;
                m_pt  <= point;
                m_br  <= brightness;
                m_bl  <= blank_of(digits, point, blank_lz);
            end
            m_cnt <= (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
            if (m_cnt == DIV - 1) m_idx <= (m_idx + 1) % 8;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one cycle and compare against the scoreboard at the falling edge.
    task automatic step();
        logic [16:0] e;
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL sb_empty observed=none expected=entry");
        end else begin
            e = exp_q.pop_front();
            assert ({anode, seg, dp, frame_tick} === e) else begin
                n_bad++;
                $error("FAIL sb_cycle observed=%h expected=%h", {anode, seg, dp, frame_tick}, e);
            end
        end
        n_cmp++;
        assert ($countones(~anode) <= 1) else begin
            n_bad++;
            $error("FAIL one_hot observed=%h expected=at_most_one_low", anode);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_tick(input string tag);
        found = 1'b0;
        for (int i = 0; i < FRAME + 16; i++) begin
            step();
            if (frame_tick === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    // Collect a full frame starting at the current (tick) cycle.
    task automatic scan_frame();
        sel_mask = 8'h00;
        low_cnt  = 0;
        seen_dp  = 8'hFF;
        for (int k = 0; k < 8; k++) seen_seg[k] = 7'h7F;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) step();
            if (anode !== 8'hFF) begin
                low_cnt++;
                sel_mask |= ~anode;
                for (int k = 0; k < 8; k++)
                    if (anode[k] == 1'b0) begin
                        seen_seg[k] = seg;
                        seen_dp[k]  = dp;
                    end
            end
        end
    endtask

    task automatic count_bad_seg(input int n, input logic [6:0] want);
        bad_seg = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (anode !== 8'hFF && seg !== want) bad_seg++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        en         = 1'b1;
        digits     = 32'h7654_3210;
        point      = 8'hFF;
        brightness = 4'd15;
        blank_lz   = 1'b0;
        steps(2);
        chk("rst_anode", 32'(anode), 32'hFF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_tick", 32'(frame_tick), 32'd0);

        // Bring-up: guard cycles, then slot 0 and slot 1.
        reset = 1'b0;
        step();
        chk("first_tick", 32'(frame_tick), 32'd1);
        chk("guard0", 32'(anode), 32'hFF);
        step();
        chk("guard1", 32'(anode), 32'hFF);
        low_cnt = 0;
        for (int i = 0; i < DIV - GUARD; i++) begin
            step();
            if (anode === 8'hFE && seg === 7'h40) low_cnt++;
        end
        chk("slot0_on", 32'(low_cnt), 32'(DIV - GUARD));
        steps(3);
        chk("slot1_anode", 32'(anode), 32'hFD);
        chk("slot1_seg", 32'(seg), 32'h79);

        // Brightness extremes and a middle setting.
        brightness = 4'd0;
        wait_tick("tick_br0");
        scan_frame();
        chk("br0_low", 32'(low_cnt), 32'd0);
        brightness = 4'd3;
        wait_tick("tick_br3");
        scan_frame();
        chk("br3_low", 32'(low_cnt), 32'(8 * 6));

        // Leading-zero blanking.
        brightness = 4'd15;
        blank_lz   = 1'b1;
        digits     = 32'h0000_0405;
        wait_tick("tick_lz");
        scan_frame();
        chk("lz_sel", 32'(sel_mask), 32'h07);
        chk("lz_d2", 32'(seen_seg[2]), 32'h19);
        chk("lz_d1", 32'(seen_seg[1]), 32'h40);
        chk("lz_d0", 32'(seen_seg[0]), 32'h12);
        chk("lz_low", 32'(low_cnt), 32'(3 * (DIV - GUARD)));
        point = 8'hEF;
        wait_tick("tick_lz_dp");
        scan_frame();
        chk("lzdp_sel", 32'(sel_mask), 32'h1F);
        chk("lzdp_d4seg", 32'(seen_seg[4]), 32'h40);
        chk("lzdp_d4dp", 32'(seen_dp[4]), 32'd0);

        // Mid-frame input change must wait for the next frame.
        blank_lz = 1'b0;
        point    = 8'hFF;
        digits   = 32'h1111_1111;
        wait_tick("tick_ones");
        count_bad_seg(3 * DIV + 5, 7'h79);
        digits = 32'h2222_2222;
        count_bad_seg(FRAME - 1 - (3 * DIV + 5), 7'h79);
        chk("tear_free", 32'(bad_seg), 32'd0);
        step();
        chk("tick_twos", 32'(frame_tick), 32'd1);
        count_bad_seg(FRAME - 1, 7'h24);
        chk("twos_frame", 32'(bad_seg), 32'd0);

        // Enable drop mid-slot, then resume at the right position.
        steps(40);
        en = 1'b0;
        found = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (anode !== 8'hFF) found = 1'b0;
        end
        chk("en_off", 32'(found), 32'd1);
        en = 1'b1;
        step();
        chk("en_resume_anode", 32'(anode), 32'hFD);
        chk("en_resume_seg", 32'(seg), 32'h24);

        // Reset in the middle of slot 5.
        steps(120);
        chk("pre_rst_slot5", 32'(anode), 32'hDF);
        reset = 1'b1;
        step();
        chk("mid_rst_anode", 32'(anode), 32'hFF);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_dp", 32'(dp), 32'd1);
        chk("mid_rst_tick", 32'(frame_tick), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("restart_tick", 32'(frame_tick), 32'd1);
        steps(2 * FRAME + 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
